reset_domain_sequencer: RTL and testbench



---
 rtl/reset_domain_sequencer.sv | 165 ++++++++++++++++
 tb/tb_reset_domain_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_domain_sequencer.sv
// Ordered, acknowledged reset release for NUM_DOMAINS downstream domains.
// Build option: define RESET_SEQ_ACK_MONITOR_EN to treat ack loss in DONE as an error.
module reset_domain_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int IDX_W       = $clog2(NUM_DOMAINS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sw_reset_req,
  input  logic [NUM_DOMAINS-1:0] domain_ack,
  output logic [NUM_DOMAINS-1:0] domain_resetn,
  output logic                   all_ready,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [IDX_W-1:0]       err_domain,
  output logic [2:0]             state_dbg
);
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int AT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [AT_W-1:0]  ACK_LAST  = AT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    ASSERT_ALL = 3'd0,
    HOLD       = 3'd1,
    WAIT_ACK   = 3'd2,
    DONE       = 3'd3,
    ERROR      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [HC_W-1:0]        hold_q, hold_d;
  logic [AT_W-1:0]        tmr_q, tmr_d;
  logic [NUM_DOMAINS-1:0] resetn_d;
  logic                   ready_d, busy_d, err_d;
  logic [IDX_W-1:0]       err_dom_d;

  assign state_dbg = state_q;

`ifdef RESET_SEQ_ACK_MONITOR_EN
  logic             mon_drop;
  logic [IDX_W-1:0] mon_idx;

  // Lowest-numbered domain whose ack has fallen.
  always_comb begin
    mon_drop = 1'b0;
    mon_idx  = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (!domain_ack[i]) begin
        mon_drop = 1'b1;
        mon_idx  = IDX_W'(i);
      end
    end
  end
`endif

  // Handshake: raising domain_resetn[idx] is the request; domain_ack[idx] high on any
  // WAIT_ACK edge completes it. Acks from any other domain, or outside WAIT_ACK, are ignored.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    tmr_d     = tmr_q;
    resetn_d  = domain_resetn;
    ready_d   = all_ready;
    busy_d    = busy;
    err_d     = timeout_err;
    err_dom_d = err_domain;
    if (sw_reset_req) begin
      state_d   = ASSERT_ALL;
      idx_d     = '0;
      hold_d    = '0;
      resetn_d  = '0;
      ready_d   = 1'b0;
      busy_d    = 1'b1;
      err_d     = 1'b0;
      err_dom_d = '0;
    end else begin
      case (state_q)
        ASSERT_ALL: begin
          state_d  = HOLD;
          idx_d    = '0;
          hold_d   = '0;
          resetn_d = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
        end
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            resetn_d[idx_q] = 1'b1;
            tmr_d           = '0;
            state_d         = WAIT_ACK;
          end else begin
            hold_d = hold_q + HC_W'(1);
          end
        end
        WAIT_ACK: begin
          if (domain_ack[idx_q]) begin
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              ready_d = 1'b1;
              busy_d  = 1'b0;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              hold_d  = '0;
              state_d = HOLD;
            end
          end else if (tmr_q == ACK_LAST) begin
            state_d         = ERROR;
            resetn_d[idx_q] = 1'b0;
            err_d           = 1'b1;
            err_dom_d       = idx_q;
            ready_d         = 1'b0;
            busy_d          = 1'b0;
          end else begin
            tmr_d = tmr_q + AT_W'(1);
          end
        end
        DONE: begin
`ifdef RESET_SEQ_ACK_MONITOR_EN
          if (mon_drop) begin
            state_d           = ERROR;
            resetn_d[mon_idx] = 1'b0;
            err_d             = 1'b1;
            err_dom_d         = mon_idx;
            ready_d           = 1'b0;
            busy_d            = 1'b0;
          end
`endif
        end
        ERROR: ;
        default: state_d = ASSERT_ALL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ASSERT_ALL;
      idx_q         <= '0;
      hold_q        <= '0;
      tmr_q         <= '0;
      domain_resetn <= '0;
      all_ready     <= 1'b0;
      busy          <= 1'b1;
      timeout_err   <= 1'b0;
      err_domain    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      tmr_q         <= tmr_d;
      domain_resetn <= resetn_d;
      all_ready     <= ready_d;
      busy          <= busy_d;
      timeout_err   <= err_d;
      err_domain    <= err_dom_d;
    end
  end
endmodule

// File: tb/tb_reset_domain_sequencer.sv
// Bench for reset_domain_sequencer: directed plan steps plus randomized runs checked
// against an event-timestamp model. Honours RESET_SEQ_ACK_MONITOR_EN.
module tb_reset_domain_sequencer;
  localparam int N  = 4;
  localparam int H  = 4;
  localparam int T  = 8;
  localparam int IW = 2;
  localparam int W  = N + 3 + IW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sw_reset_req = 1'b0;
  logic [N-1:0]  domain_ack = '0;
  logic [N-1:0]  domain_resetn;
  logic          all_ready, busy, timeout_err;
  logic [IW-1:0] err_domain;
  logic [2:0]    state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  // responder controls
  int           delay [N];
  int           cnt   [N];
  int           rise_edge [N];
  logic [N-1:0] force_hi = '0;
  logic [N-1:0] tie0     = '0;
  logic [N-1:0] prev_rn  = '0;

  // reference model
  logic [N-1:0]  exp_resetn = '0;
  logic          exp_ready = 1'b0, exp_busy = 1'b1, exp_err = 1'b0;
  logic [IW-1:0] exp_errdom = '0;
  bit            m_pending = 1'b1, m_waiting = 1'b0, m_done = 1'b0, m_failed = 1'b0, m_rst = 1'b0;
  int            m_cur = 0, m_next_rel = 0, m_deadline = 0;
  logic [W-1:0]  exp_q[$];

  reset_domain_sequencer #(
    .NUM_DOMAINS(N), .HOLD_CYCLES(H), .ACK_TIMEOUT(T), .IDX_W(IW)
  ) dut (
    .clock(clock), .reset(reset), .sw_reset_req(sw_reset_req), .domain_ack(domain_ack),
    .domain_resetn(domain_resetn), .all_ready(all_ready), .busy(busy),
    .timeout_err(timeout_err), .err_domain(err_domain), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_fail(input int d);
    exp_resetn[d] = 1'b0;
    exp_err    = 1'b1;
    exp_errdom = IW'(d);
    exp_ready  = 1'b0;
    exp_busy   = 1'b0;
    m_done     = 1'b0;
    m_failed   = 1'b1;
  endtask

  // Timeline model: each release is scheduled H edges after the previous milestone,
  // and each wait has an absolute deadline T edges after its release.
  task automatic model_edge();
    m_rst = 1'b0;
    if (reset || sw_reset_req) begin
      exp_resetn = '0; exp_ready = 1'b0; exp_busy = 1'b1; exp_err = 1'b0; exp_errdom = '0;
      m_pending = 1'b1; m_waiting = 1'b0; m_done = 1'b0; m_failed = 1'b0; m_cur = 0;
      m_rst = reset;
    end else if (m_pending) begin
      m_pending  = 1'b0;
      m_cur      = 0;
      m_next_rel = cyc + H;
    end else if (m_done) begin
`ifdef RESET_SEQ_ACK_MONITOR_EN
      if (domain_ack != {N{1'b1}}) begin
        int low;
        low = 0;
        for (int i = N - 1; i >= 0; i--) if (!domain_ack[i]) low = i;
        model_fail(low);
      end
`endif
    end else if (m_failed) begin
      m_failed = 1'b1;
    end else if (!m_waiting) begin
      if (cyc == m_next_rel) begin
        exp_resetn[m_cur] = 1'b1;
        m_waiting  = 1'b1;
        m_deadline = cyc + T;
      end
    end else begin
      if (domain_ack[m_cur]) begin
        m_waiting = 1'b0;
        if (m_cur == N - 1) begin
          m_done = 1'b1; exp_ready = 1'b1; exp_busy = 1'b0;
        end else begin
          m_cur++;
          m_next_rel = cyc + H;
        end
      end else if (cyc == m_deadline) begin
        m_waiting = 1'b0;
        model_fail(m_cur);
      end
    end
    exp_q.push_back({exp_resetn, exp_ready, exp_busy, exp_err, exp_errdom});
  endtask

  // scoreboard
  task automatic check_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk("domain_resetn", 32'(domain_resetn), 32'(e[W-1 -: N]));
    chk("all_ready", 32'(all_ready), 32'(e[IW+2]));
    chk("busy", 32'(busy), 32'(e[IW+1]));
    chk("timeout_err", 32'(timeout_err), 32'(e[IW]));
    if (e[IW] || m_rst) chk("err_domain", 32'(err_domain), 32'(e[IW-1:0]));
    chk("single_rise", 32'($countones(domain_resetn & ~prev_rn) <= 1), 32'd1);
  endtask

  // Ack responder: ack[i] rises delay[i] clocks after domain_resetn[i] is seen high.
  task automatic respond();
    for (int i = 0; i < N; i++) begin
      if (domain_resetn[i] && !prev_rn[i]) rise_edge[i] = cyc;
      if (domain_resetn[i]) cnt[i] = prev_rn[i] ? cnt[i] + 1 : 0;
      else cnt[i] = 0;
      domain_ack[i] = force_hi[i] | (!tie0[i] & domain_resetn[i] & (cnt[i] >= delay[i]));
    end
    prev_rn = domain_resetn;
  endtask

  // driver
  task automatic step();
    @(posedge clock);
    cyc++;
    model_edge();
    #1;
    check_outputs();
    respond();
  endtask

  task automatic run_until_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(all_ready || timeout_err) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(n >= budget), 32'd0);
  endtask

  task automatic restart();
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    base = cyc;
  endtask

  task automatic set_delays(input int d);
    for (int i = 0; i < N; i++) delay[i] = d;
  endtask

  initial begin
    set_delays(2);
    for (int i = 0; i < N; i++) begin cnt[i] = 0; rise_edge[i] = 0; end

    // nominal sequence after power-on reset
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    base = cyc;
    run_until_end("nominal_budget", 60);
    chk("rel0_edge", 32'(rise_edge[0] - base), 32'd5);
    for (int i = 1; i < N; i++) chk("rel_gap", 32'(rise_edge[i] - rise_edge[i-1]), 32'd7);
    chk("done_edge", 32'(cyc - base), 32'd29);
    chk("done_ready", 32'(all_ready), 32'd1);
    repeat (4) step();

    // one-clock re-sequence from DONE
    restart();
    chk("restart_busy", 32'(busy), 32'd1);
    run_until_end("reseq_budget", 60);
    chk("reseq_rel0", 32'(rise_edge[0] - base), 32'd5);
    chk("reseq_rel3", 32'(rise_edge[3] - base), 32'd26);

    // request held for 5 clocks
    sw_reset_req = 1'b1;
    repeat (5) begin
      step();
      chk("held_resetn", 32'(domain_resetn), 32'd0);
    end
    sw_reset_req = 1'b0;
    base = cyc;
    run_until_end("held_budget", 60);
    chk("held_rel0", 32'(rise_edge[0] - base), 32'd5);

    // domain 2 never acks
    tie0 = 4'b0100;
    restart();
    run_until_end("timeout_budget", 60);
    chk("timeout_gap", 32'(cyc - rise_edge[2]), 32'd8);
    chk("timeout_dom", 32'(err_domain), 32'd2);
    chk("timeout_resetn", 32'(domain_resetn), 32'h3);
    repeat (10) step();
    chk("timeout_hold", 32'(timeout_err), 32'd1);
    tie0 = '0;

    // domain 3 ack high from the start is ignored until its release
    force_hi = 4'b1000;
    restart();
    run_until_end("early_ack_budget", 60);
    chk("early_ack_rel3", 32'(rise_edge[3] - base), 32'd26);
    chk("early_ack_done", 32'(cyc - base), 32'd27);
    force_hi = '0;

    // ack on the timeout edge wins; one later times out
    delay[1] = 7;
    restart();
    run_until_end("ack_at_deadline_budget", 80);
    chk("ack_at_deadline_err", 32'(timeout_err), 32'd0);
    delay[1] = 8;
    restart();
    run_until_end("ack_late_budget", 80);
    chk("ack_late_err", 32'(timeout_err), 32'd1);
    chk("ack_late_dom", 32'(err_domain), 32'd1);
    set_delays(2);

    // restart request coinciding with an ack
    restart();
    for (int n = 0; n < 40 && !(domain_ack[1] && cnt[1] == 2); n++) step();
    chk("coincide_ack_seen", 32'(domain_ack[1]), 32'd1);
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    chk("coincide_resetn", 32'(domain_resetn), 32'd0);
    chk("coincide_busy", 32'(busy), 32'd1);
    run_until_end("coincide_budget", 60);

    // ack drop while in DONE
    chk("drop_pre_ready", 32'(all_ready), 32'd1);
    tie0 = 4'b0010;
    domain_ack[1] = 1'b0;
    step();
`ifdef RESET_SEQ_ACK_MONITOR_EN
    chk("drop_err", 32'(timeout_err), 32'd1);
    chk("drop_dom", 32'(err_domain), 32'd1);
    chk("drop_resetn", 32'(domain_resetn), 32'hd);
`else
    repeat (3) step();
    chk("drop_ignored", 32'(all_ready), 32'd1);
`endif
    tie0 = '0;

    // randomized runs
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++) delay[i] = $urandom_range(1, 9);
      force_hi = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      tie0     = ($urandom_range(0, 4) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      restart();
      for (int n = 0; n < 70; n++) begin
        sw_reset_req = ($urandom_range(0, 59) == 0);
        step();
      end
      sw_reset_req = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
